// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control unit: decodes the ID instruction and carries stage-aligned
// control through ID/EX, EX/MEM and MEM/WB, with load-use hazard detection.
module ctrl_pipe #(
  parameter int RD_W           = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int STORE_DATA_FWD = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [31:0]     id_ir,
  input  logic            id_valid,
  input  logic            stall_ext,
  input  logic            flush_ex,
  output logic            hazard_stall,
  output logic            id_illegal,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src1,
  output logic            ex_alu_src2,
  output logic [2:0]      ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic [RD_W-1:0] ex_rd,
  output logic            mem_valid,
  output logic            mem_read,
  output logic            mem_write,
  output logic [RD_W-1:0] mem_rd,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [1:0]      wb_reg_src,
  output logic [RD_W-1:0] wb_rd
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef struct packed {
    logic            valid;
    logic [3:0]      alu_op;
    logic            alu_src1;
    logic            alu_src2;
    logic [2:0]      branch;
    logic            jal;
    logic            jalr;
    logic [RD_W-1:0] rd;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [1:0]      reg_src;
  } idex_t;

  typedef struct packed {
    logic            valid;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [1:0]      reg_src;
    logic [RD_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [1:0]      reg_src;
    logic [RD_W-1:0] rd;
  } memwb_t;

  idex_t  idex_q, dec;
  exmem_t exmem_q;
  memwb_t memwb_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_lui, is_op, is_opimm;
  logic legal, uses_rs1, uses_rs2, rs1_hit, rs2_hit, store_fwd;
  logic unused_ir_bits;

  assign opcode    = id_ir[6:0];
  assign funct3    = id_ir[14:12];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign legal     = is_load | is_store | is_branch | is_jal | is_jalr |
                     is_auipc | is_lui | is_op | is_opimm;
  assign unused_ir_bits = ^{id_ir[31], id_ir[29:25]};

  always_comb begin
    dec = '0;
    dec.valid = id_valid & legal;
    if (is_op)
      dec.alu_op = {id_ir[30], funct3};
    else if (is_opimm)
      dec.alu_op = {(funct3 == 3'b101) & id_ir[30], funct3};
    else if (is_branch)
      dec.alu_op = 4'b1000;
    else if (is_lui)
      dec.alu_op = 4'b1111;
    dec.alu_src1  = is_auipc;
    dec.alu_src2  = is_opimm | is_load | is_store | is_auipc | is_lui;
    dec.branch    = {is_branch, id_ir[14], id_ir[12]};
    dec.jal       = is_jal;
    dec.jalr      = is_jalr;
    dec.rd        = RD_W'(id_ir[11:7]);
    dec.mem_read  = is_load;
    dec.mem_write = is_store;
    dec.reg_write = legal & ~(is_branch | is_store) & (id_ir[11:7] != 5'd0);
    dec.reg_src   = (is_jal | is_jalr) ? 2'b10 : (is_load ? 2'b01 : 2'b00);
  end

  // Store data is forwarded in MEM, so a store only needs its rs2 when forwarding is off.
  assign store_fwd = is_store & (STORE_DATA_FWD != 0);
  assign uses_rs1  = legal & ~(is_lui | is_auipc | is_jal);
  assign uses_rs2  = is_op | is_branch | is_store;
  assign rs1_hit   = uses_rs1 & (RD_W'(id_ir[19:15]) == idex_q.rd);
  assign rs2_hit   = uses_rs2 & ~store_fwd & (RD_W'(id_ir[24:20]) == idex_q.rd);

  assign hazard_stall = (LOAD_USE_STALL != 0) & id_valid & idex_q.valid & idex_q.mem_read &
                        (idex_q.rd != '0) & (rs1_hit | rs2_hit);
  assign id_illegal   = id_valid & ~legal;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (!stall_ext) begin
      memwb_q.valid     <= exmem_q.valid;
      memwb_q.reg_write <= exmem_q.reg_write;
      memwb_q.reg_src   <= exmem_q.reg_src;
      memwb_q.rd        <= exmem_q.rd;
      exmem_q.valid     <= idex_q.valid;
      exmem_q.mem_read  <= idex_q.mem_read;
      exmem_q.mem_write <= idex_q.mem_write;
      exmem_q.reg_write <= idex_q.reg_write;
      exmem_q.reg_src   <= idex_q.reg_src;
      exmem_q.rd        <= idex_q.rd;
      idex_q            <= (flush_ex | hazard_stall | ~dec.valid) ? '0 : dec;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_alu_op    = idex_q.alu_op;
  assign ex_alu_src1  = idex_q.alu_src1;
  assign ex_alu_src2  = idex_q.alu_src2;
  assign ex_branch    = {idex_q.valid & idex_q.branch[2], idex_q.branch[1:0]};
  assign ex_jal       = idex_q.valid & idex_q.jal;
  assign ex_jalr      = idex_q.valid & idex_q.jalr;
  assign ex_rd        = idex_q.rd;
  assign mem_valid    = exmem_q.valid;
  assign mem_read     = exmem_q.valid & exmem_q.mem_read;
  assign mem_write    = exmem_q.valid & exmem_q.mem_write;
  assign mem_rd       = exmem_q.rd;
  assign wb_valid     = memwb_q.valid;
  assign wb_reg_write = memwb_q.valid & memwb_q.reg_write;
  assign wb_reg_src   = memwb_q.reg_src;
  assign wb_rd        = memwb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed vector table plus randomized stream against a
// per-instruction reference model of the three-stage control pipeline.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rstn, id_valid, stall_ext, flush_ex;
  logic [31:0] id_ir;
  logic        hazard_stall, id_illegal, ex_valid, ex_alu_src1, ex_alu_src2, ex_jal, ex_jalr;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_branch;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        mem_valid, mem_read, mem_write, wb_valid, wb_reg_write;
  logic [1:0]  wb_reg_src;

  logic        n_hazard_stall, n_id_illegal, n_ex_valid, n_ex_alu_src1, n_ex_alu_src2, n_ex_jal, n_ex_jalr;
  logic [3:0]  n_ex_alu_op;
  logic [2:0]  n_ex_branch;
  logic [4:0]  n_ex_rd, n_mem_rd, n_wb_rd;
  logic        n_mem_valid, n_mem_read, n_mem_write, n_wb_valid, n_wb_reg_write;
  logic [1:0]  n_wb_reg_src;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .rstn(rstn), .id_ir(id_ir), .id_valid(id_valid), .stall_ext(stall_ext),
    .flush_ex(flush_ex), .hazard_stall(hazard_stall), .id_illegal(id_illegal),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src1(ex_alu_src1),
    .ex_alu_src2(ex_alu_src2), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_reg_src(wb_reg_src), .wb_rd(wb_rd)
  );

  ctrl_pipe #(.LOAD_USE_STALL(0)) dut_nl (
    .clk(clk), .rstn(rstn), .id_ir(id_ir), .id_valid(id_valid), .stall_ext(stall_ext),
    .flush_ex(flush_ex), .hazard_stall(n_hazard_stall), .id_illegal(n_id_illegal),
    .ex_valid(n_ex_valid), .ex_alu_op(n_ex_alu_op), .ex_alu_src1(n_ex_alu_src1),
    .ex_alu_src2(n_ex_alu_src2), .ex_branch(n_ex_branch), .ex_jal(n_ex_jal), .ex_jalr(n_ex_jalr),
    .ex_rd(n_ex_rd), .mem_valid(n_mem_valid), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .mem_rd(n_mem_rd), .wb_valid(n_wb_valid), .wb_reg_write(n_wb_reg_write),
    .wb_reg_src(n_wb_reg_src), .wb_rd(n_wb_rd)
  );

  typedef struct packed {
    bit       valid;
    bit [3:0] alu_op;
    bit       s1, s2;
    bit [2:0] br;
    bit       jal, jalr;
    bit [4:0] rd;
    bit       mrd, mwr, rw;
    bit [1:0] rsrc;
  } rec_t;

  typedef struct {
    bit r, se, fl, v;
    logic [31:0] ir;
    int hz, ill, exv, aluop, src2, exbr, memv, wbw, wbrd, wbsrc;
  } vec_t;

  localparam int D = -1;
  localparam logic [31:0] SUB = 32'h402081B3, ADDI5 = 32'h00700293, LW1 = 32'h00012083,
    ADD4 = 32'h00508233, BEQ = 32'h00208463, ADDI6 = 32'h00100313, ILL = 32'h0000007F,
    ADDI0 = 32'h00100013, SW1 = 32'h00112023;

  rec_t pipe [3];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic opt(input string name, input logic [63:0] act, input int e);
    if (e >= 0) chk(name, act, 64'(e));
  endtask

  // Reference decode: one case per opcode, fields set straight from the ISA control table.
  function automatic rec_t m_dec(input logic [31:0] ir);
    rec_t r = '0;
    r.valid = 1'b1;
    r.rd    = ir[11:7];
    r.br    = {1'b0, ir[14], ir[12]};
    r.rw    = (ir[11:7] != 5'd0);
    case (ir[6:0])
      7'b0110011: r.alu_op = {ir[30], ir[14:12]};
      7'b0010011: begin r.alu_op = {(ir[14:12] == 3'b101) ? ir[30] : 1'b0, ir[14:12]}; r.s2 = 1; end
      7'b0000011: begin r.s2 = 1; r.mrd = 1; r.rsrc = 2'b01; end
      7'b0100011: begin r.s2 = 1; r.mwr = 1; r.rw = 0; end
      7'b1100011: begin r.alu_op = 4'b1000; r.br[2] = 1; r.rw = 0; end
      7'b1101111: begin r.jal = 1; r.rsrc = 2'b10; end
      7'b1100111: begin r.jalr = 1; r.rsrc = 2'b10; end
      7'b0010111: begin r.s1 = 1; r.s2 = 1; end
      7'b0110111: begin r.alu_op = 4'b1111; r.s2 = 1; end
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic bit m_hazard(input logic [31:0] ir, input bit v, input rec_t ex);
    bit [6:0] op = ir[6:0];
    bit legal = m_dec(ir).valid;
    bit r1 = legal && !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    bit r2 = (op == 7'b0110011 || op == 7'b1100011 || op == 7'b0100011);
    if (!(v && ex.valid && ex.mrd && ex.rd != 0)) return 0;
    if (r1 && ir[19:15] == ex.rd) return 1;
    if (r2 && ir[24:20] == ex.rd && op != 7'b0100011) return 1;
    return 0;
  endfunction

  task automatic drive_cycle(input bit r, se, fl, v, input logic [31:0] ir, input int e_hz, e_ill);
    rec_t d;
    bit hz, ill;
    logic [33:0] exp_v, act_v;
    rstn = r; stall_ext = se; flush_ex = fl; id_valid = v; id_ir = ir;
    #1;
    d   = m_dec(ir);
    ill = v && !d.valid;
    hz  = m_hazard(ir, v, pipe[0]);
    chk("hazard_stall", 64'(hazard_stall), 64'(hz));
    chk("id_illegal", 64'(id_illegal), 64'(ill));
    chk("nostall_hazard", 64'(n_hazard_stall), 64'(0));
    opt("tbl_hazard", 64'(hazard_stall), e_hz);
    opt("tbl_illegal", 64'(id_illegal), e_ill);
    @(posedge clk);
    if (!r) begin
      pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    end else if (!se) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (fl || hz || !v || !d.valid) ? '0 : d;
    end
    #1;
    exp_v = {pipe[0].valid, pipe[0].alu_op, pipe[0].s1, pipe[0].s2, pipe[0].valid & pipe[0].br[2],
             pipe[0].br[1:0], pipe[0].jal, pipe[0].jalr, pipe[0].rd,
             pipe[1].valid, pipe[1].mrd, pipe[1].mwr, pipe[1].rd,
             pipe[2].valid, pipe[2].rw, pipe[2].rsrc, pipe[2].rd};
    act_v = {ex_valid, ex_alu_op, ex_alu_src1, ex_alu_src2, ex_branch, ex_jal, ex_jalr, ex_rd,
             mem_valid, mem_read, mem_write, mem_rd, wb_valid, wb_reg_write, wb_reg_src, wb_rd};
    chk("stage_regs", 64'(act_v), 64'(exp_v));
  endtask

  function automatic vec_t mk(input bit r, se, fl, v, input logic [31:0] ir,
                              input int hz, ill, exv, aluop, src2, exbr, memv, wbw, wbrd, wbsrc);
    vec_t t;
    t.r = r; t.se = se; t.fl = fl; t.v = v; t.ir = ir;
    t.hz = hz; t.ill = ill; t.exv = exv; t.aluop = aluop; t.src2 = src2;
    t.exbr = exbr; t.memv = memv; t.wbw = wbw; t.wbrd = wbrd; t.wbsrc = wbsrc;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    //          r se fl v  ir     hz ill exv aop src2 exbr memv wbw wbrd wbsrc
    tbl.push_back(mk(0,0,0,0,32'h0,  0,0, 0,D,D,0,0,0,D,0));
    tbl.push_back(mk(0,0,0,0,32'h0,  0,0, 0,D,D,0,0,0,D,0));
    tbl.push_back(mk(1,0,0,1,SUB,    0,0, 1,8,0,D,0,0,D,D));
    tbl.push_back(mk(1,0,0,1,ADDI5,  0,0, 1,0,1,D,1,0,D,D));
    tbl.push_back(mk(1,0,0,0,32'h0,  0,0, 0,D,D,D,1,1,3,0));
    tbl.push_back(mk(1,0,0,1,LW1,    0,0, 1,0,1,D,0,1,5,0));
    tbl.push_back(mk(1,0,0,1,ADD4,   1,0, 0,D,D,D,1,0,D,D));
    tbl.push_back(mk(1,0,0,1,ADD4,   0,0, 1,0,0,D,0,1,1,1));
    tbl.push_back(mk(1,0,0,1,BEQ,    0,0, 1,8,0,4,1,0,D,D));
    tbl.push_back(mk(1,0,1,1,ADDI6,  0,0, 0,D,D,0,1,1,4,0));
    tbl.push_back(mk(1,0,0,1,ADDI5,  0,0, 1,D,D,D,D,D,D,D));
    tbl.push_back(mk(1,0,0,1,SUB,    0,0, 1,8,D,D,D,D,D,D));
    tbl.push_back(mk(1,0,0,1,ADDI6,  0,0, 1,0,1,D,1,1,5,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,0,1,ADD4, 0,0, 1,0,1,D,1,1,5,0));
    tbl.push_back(mk(1,0,0,1,ADD4,   0,0, 1,0,0,D,1,1,3,0));
    tbl.push_back(mk(1,0,0,1,ILL,    0,1, 0,D,D,D,D,D,D,D));
    tbl.push_back(mk(1,0,0,1,ADDI0,  0,0, 1,0,1,D,D,D,D,D));
    tbl.push_back(mk(1,0,0,0,32'h0,  0,0, 0,D,D,D,D,D,D,D));
    tbl.push_back(mk(1,0,0,0,32'h0,  0,0, 0,D,D,D,D,0,0,D));
    tbl.push_back(mk(1,0,0,1,LW1,    0,0, 1,D,D,D,D,D,D,D));
    tbl.push_back(mk(1,0,0,1,SW1,    0,0, 1,D,D,D,D,D,D,D));
    tbl.push_back(mk(1,0,0,1,LW1,    0,0, 1,D,D,D,D,D,D,D));
    tbl.push_back(mk(1,0,1,1,ADD4,   1,0, 0,D,D,D,1,D,D,D));
    tbl.push_back(mk(1,0,0,1,ADD4,   0,0, 1,D,D,D,D,D,D,D));
    tbl.push_back(mk(0,0,0,1,LW1,    0,0, 0,D,D,D,0,0,D,0));
    tbl.push_back(mk(1,0,0,0,32'h0,  0,0, 0,D,D,D,0,0,D,0));

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].r, tbl[i].se, tbl[i].fl, tbl[i].v, tbl[i].ir, tbl[i].hz, tbl[i].ill);
      opt("ex_valid", 64'(ex_valid), tbl[i].exv);
      opt("ex_alu_op", 64'(ex_alu_op), tbl[i].aluop);
      opt("ex_alu_src2", 64'(ex_alu_src2), tbl[i].src2);
      opt("ex_branch", 64'(ex_branch), tbl[i].exbr);
      opt("mem_valid", 64'(mem_valid), tbl[i].memv);
      opt("wb_reg_write", 64'(wb_reg_write), tbl[i].wbw);
      opt("wb_rd", 64'(wb_rd), tbl[i].wbrd);
      opt("wb_reg_src", 64'(wb_reg_src), tbl[i].wbsrc);
    end

    for (int i = 0; i < 800; i++) begin
      logic [6:0] ops [11];
      logic [6:0] op;
      logic [31:0] ir;
      ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111,
              7'b0110111, 7'b0110011, 7'b0010011, 7'b1111111, 7'b0001111};
      op = ($urandom_range(0, 9) < 3) ? 7'b0000011 : ops[$urandom_range(0, 10)];
      ir = {1'b0, 1'($urandom), 5'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
      drive_cycle($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0, ir, D, D);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 5-stage RV32I core. It decodes the ID-stage instruction into a full RV32I ALU/branch/memory/write-back control set and carries those signals through ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards and handles bubbles, flushes and global stalls, so the datapath receives stage-aligned control with no decode logic of its own.

## Interface
- `RD_W`, default 5: width of the register-address fields.
- `LOAD_USE_STALL`, default 1: 1 means load-use detection is active; 0 means `hazard_stall` is tied to 0 and an external forwarding unit covers load-use.
- `STORE_DATA_FWD`, default 1: 1 means a load followed by a store whose rs2 matches does not stall, because store data is forwarded in MEM; 0 means it stalls.
- `clk` in 1: the single clock.
- `rstn` in 1: reset, synchronous and active-low.
- `id_ir` in 32: the IF/ID instruction.
- `id_valid` in 1: `id_ir` holds a real instruction.
- `stall_ext` in 1: global freeze, for example a memory wait.
- `flush_ex` in 1: a taken branch or jump is resolved in EX; kill the ID instruction.
- `hazard_stall` out 1: combinational; when high, hold PC and IF/ID.
- `id_illegal` out 1: combinational; `id_valid` is high and the opcode is unsupported.
- `ex_valid` out 1, `ex_alu_op` out 4, `ex_alu_src1` out 1, `ex_alu_src2` out 1, `ex_branch` out 3, `ex_jal` out 1, `ex_jalr` out 1, `ex_rd` out `RD_W`.
- `mem_valid` out 1, `mem_read` out 1, `mem_write` out 1, `mem_rd` out `RD_W`.
- `wb_valid` out 1, `wb_reg_write` out 1, `wb_reg_src` out 2, `wb_rd` out `RD_W`.

## Operation
- Supported opcodes: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111, LUI 0110111, OP 0110011, OP-IMM 0010011. Any other opcode decodes to a bubble and raises `id_illegal`.
- ALU op for OP instructions is {ir[30], funct3}.
- ALU op for OP-IMM is {ir[30] if funct3==101, else 0; funct3}.
- ALU op for BRANCH is 1000 (SUB).
- ALU op for LUI is 1111 (pass src2).
- ALU op for every other opcode is 0000 (ADD).
- `alu_src1`=1 only for AUIPC (use PC).
- `alu_src2`=1 (use immediate) for OP-IMM, LOAD, STORE, AUIPC and LUI.
- `branch` = {is_branch, ir[14], ir[12]}.
- `reg_write` = not (BRANCH or STORE), and is forced to 0 when rd==0.
- `reg_src`: 00 for ALU, 01 for LOAD, 10 for JAL/JALR (PC+4).
- Register usage:
  - rs1 is read by every opcode except LUI, AUIPC and JAL.
  - rs2 is read by OP, BRANCH and STORE.
- Load-use hazard:
  - `hazard_stall` = `LOAD_USE_STALL` and `id_valid` and `ex_valid` and `ex_mem_read` and `ex_rd`≠0.
  - It also requires one of: rs1 is read and matches `ex_rd`, or rs2 is read and matches `ex_rd`.
  - A STORE whose rs2 matches is excluded when `STORE_DATA_FWD`=1.
- Register update on each rising edge, in priority order:
  1. `rstn`=0: all valid bits and all control fields are 0.
  2. `stall_ext`=1: all three registers hold. `flush_ex` and `hazard_stall` are ignored that cycle; the branch remains in EX, so `flush_ex` stays asserted.
  3. `flush_ex`=1: ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
  4. `hazard_stall`=1: ID/EX loads a bubble. EX/MEM and MEM/WB advance.
  5. Otherwise: ID/EX takes the decoded ID instruction (valid = `id_valid` and not illegal), and the other registers shift.
- A bubble has every field equal to 0.
- Every side-effecting output (`mem_read`, `mem_write`, `wb_reg_write`, `ex_branch[2]`, `ex_jal`, `ex_jalr`) is 0 whenever its stage valid bit is 0.

## Timing
- Every registered output is 0 in the cycle after reset is sampled low.
- Latency: an instruction accepted at edge N is visible on `ex_*` during cycle N+1, on `mem_*` during N+2 and on `wb_*` during N+3.
- `hazard_stall` and `id_illegal` are combinational from `id_ir`/`id_valid` and the ID/EX register, with no cycle delay.
- A load-use stall inserts exactly one bubble. In the following cycle the load is in MEM and `hazard_stall` drops.
- When reset is applied mid-stream, in-flight instructions are discarded with no partial write-back.
- `flush_ex` and `hazard_stall` both high: the flush takes precedence. The result is the same single bubble, and the stalled ID instruction is discarded.

## Test plan
- Reset: hold `rstn`=0 for 2 cycles, then release. Expect all valid bits, `mem_read`/`mem_write`, `wb_reg_write` and `wb_reg_src` to be 0.
- `sub x3,x1,x2` (0x402081B3), then `addi x5,x0,7`:
  - SUB reaches EX one cycle after acceptance with `ex_alu_op`=1000, `ex_alu_src2`=0.
  - One cycle later `ex_alu_op`=0000, `ex_alu_src2`=1.
  - `wb_reg_write`=1 with `wb_rd`=3 three cycles after SUB was accepted.
- `lw x1,0(x2)`, then `add x4,x1,x5`:
  - `hazard_stall`=1 for exactly one cycle, and `ex_valid`=0 in the following cycle.
  - ADD then enters EX. WB shows `wb_reg_src`=01 for LW.
  - With `LOAD_USE_STALL`=0 there is no stall.
- `beq` in EX with `flush_ex`=1 and the next instruction in ID: the next cycle `ex_valid`=0 and `ex_branch`=000, while the branch advances to MEM.
- `stall_ext`=1 for 3 cycles with the pipeline full: every `ex_*`, `mem_*` and `wb_*` output is unchanged across all 3 cycles and resumes shifting after release.
- Opcode 0x0000007F: `id_illegal`=1 and a bubble enters EX. `addi x0,x0,1`: `ex_valid`=1 but `wb_reg_write`=0.
